// File: rtl/mcu_spi_host_if.sv
// mcu_spi_host_if
//   Requester-side bundle of mcu_spi_host: byte stream in, byte stream out,
//   abort and busy status.
//
//   Handshake: a byte moves from requester to host on every rising clk edge
//   where tx_valid and tx_ready are both 1. The requester keeps tx_data and
//   tx_last stable while tx_valid=1 and tx_ready=0. rx_valid is a
//   single-cycle pulse with no ready; the requester must take rx_data then.
//
//   Modports:
//     master - the requester (drives tx_valid/tx_data/tx_last/abort)
//     slave  - the SPI host (drives tx_ready/rx_valid/rx_data/busy)
interface mcu_spi_host_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       abort;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;

  modport master (
    output tx_valid, tx_data, tx_last, abort,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last, abort,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/mcu_spi_host.sv
// mcu_spi_host
//   SPI mode-0 initiator for the MCU control link. Full duplex, MSB first:
//   sclk idles low, mosi changes on sclk fall, miso is sampled on sclk rise.
//   One byte is returned on rx for each byte sent.
//
//   Parameters:
//     CLK_DIV   sclk half-period in clk cycles (>= 1)
//   Build option:
//     MCU_SPI_HOST_INTN_EN  when defined, spi_intn is synchronized and drives
//                           irq / irq_fall; otherwise both are tied to 0.
//   Ports:
//     clk, reset_n         clock (clk32 domain), async active-low reset
//     req (slave modport)  tx_valid/tx_ready/tx_data/tx_last, abort,
//                          rx_valid/rx_data, busy
//     irq, irq_fall        interrupt level and falling-edge pulse
//     spi_sclk, spi_csn, spi_mosi, spi_miso, spi_intn   target pins
//     dbg_state            current FSM state encoding
module mcu_spi_host #(
  parameter int CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  mcu_spi_host_if.slave  req,
  output logic           irq,
  output logic           irq_fall,
  output logic           spi_sclk,
  output logic           spi_csn,
  output logic           spi_mosi,
  input  logic           spi_miso,
  input  logic           spi_intn,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    HOLD   = 3'd2,
    CS_END = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int               CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             last_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
  logic             sclk_q;
  logic             csn_q;
  logic             mosi_q;

  logic accept;
  logic cnt_done;
  logic abort_hit;

  // tx_ready_q is only ever 1 in IDLE or HOLD, so this is a legal accept.
  assign accept    = req.tx_valid & tx_ready_q;
  assign cnt_done  = (cnt == CNT_LAST);
  assign abort_hit = req.abort &
                     ((state == SHIFT) | (state == HOLD) | (state == CS_END));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      tx_sh      <= 8'h00;
      rx_sh      <= 8'h00;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      sclk_q     <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (abort_hit) begin
        // Abort wins over a same-cycle accept in HOLD; partial byte is dropped.
        state      <= GAP;
        cnt        <= '0;
        csn_q      <= 1'b1;
        sclk_q     <= 1'b0;
        mosi_q     <= 1'b0;
        tx_ready_q <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            sclk_q <= 1'b0;
            if (accept) begin
              // First bit goes out immediately; csn falls here on a new frame.
              state      <= SHIFT;
              cnt        <= '0;
              bit_idx    <= 3'd0;
              tx_sh      <= req.tx_data;
              mosi_q     <= req.tx_data[7];
              last_q     <= req.tx_last;
              csn_q      <= 1'b0;
              tx_ready_q <= 1'b0;
            end else begin
              tx_ready_q <= 1'b1;
            end
          end
          SHIFT: begin
            if (cnt_done) begin
              cnt <= '0;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
                rx_sh  <= {rx_sh[6:0], spi_miso};
              end else begin
                sclk_q <= 1'b0;
                if (bit_idx == 3'd7) begin
                  // mosi keeps bit0 after the last fall.
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= rx_sh;
                  if (last_q) begin
                    state <= CS_END;
                  end else begin
                    state      <= HOLD;
                    tx_ready_q <= 1'b1;
                  end
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  mosi_q  <= tx_sh[6];
                  tx_sh   <= {tx_sh[6:0], 1'b0};
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          CS_END: begin
            if (cnt_done) begin
              cnt    <= '0;
              csn_q  <= 1'b1;
              mosi_q <= 1'b0;
              state  <= GAP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt_done) begin
              cnt        <= '0;
              state      <= IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state      <= IDLE;
            cnt        <= '0;
            csn_q      <= 1'b1;
            sclk_q     <= 1'b0;
            tx_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req.tx_ready = tx_ready_q;
  assign req.rx_valid = rx_valid_q;
  assign req.rx_data  = rx_data_q;
  assign req.busy     = ~csn_q | (state == GAP);
  assign spi_sclk     = sclk_q;
  assign spi_csn      = csn_q;
  assign spi_mosi     = mosi_q;
  assign dbg_state    = state;

`ifdef MCU_SPI_HOST_INTN_EN
  // Two-flop synchronizer plus one delay flop for edge detection; all reset
  // to 1 so no interrupt is reported coming out of reset.
  logic intn_s1;
  logic intn_s2;
  logic intn_s3;
  logic irq_fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intn_s1    <= 1'b1;
      intn_s2    <= 1'b1;
      intn_s3    <= 1'b1;
      irq_fall_q <= 1'b0;
    end else begin
      intn_s1    <= spi_intn;
      intn_s2    <= intn_s1;
      intn_s3    <= intn_s2;
      irq_fall_q <= intn_s3 & ~intn_s2;
    end
  end

  assign irq      = ~intn_s2;
  assign irq_fall = irq_fall_q;
`else
  logic unused_intn;
  assign unused_intn = spi_intn;
  assign irq         = 1'b0;
  assign irq_fall    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_host.sv
// tb_mcu_spi_host
//   Directed bench for mcu_spi_host: a CLK_DIV=2 instance with a streaming
//   target model and a CLK_DIV=1 instance with miso held high.
module tb_mcu_spi_host;

`ifdef MCU_SPI_HOST_INTN_EN
  localparam bit INTN_EN = 1'b1;
`else
  localparam bit INTN_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic intn;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  mcu_spi_host_if bus2();
  mcu_spi_host_if bus1();
  logic sclk2, csn2, mosi2, miso2, irq2, irqf2;
  logic sclk1, csn1, mosi1, miso1, irq1, irqf1;
  logic [2:0] st2, st1;

  mcu_spi_host #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(bus2), .irq(irq2), .irq_fall(irqf2),
    .spi_sclk(sclk2), .spi_csn(csn2), .spi_mosi(mosi2), .spi_miso(miso2),
    .spi_intn(intn), .dbg_state(st2)
  );

  mcu_spi_host #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(bus1), .irq(irq1), .irq_fall(irqf1),
    .spi_sclk(sclk1), .spi_csn(csn1), .spi_mosi(mosi1), .spi_miso(miso1),
    .spi_intn(intn), .dbg_state(st1)
  );

  // ---------------- target model / monitors ----------------
  // Mode-0 target: present MSB before the first rise, shift on every fall.
  logic [31:0] tgt2 = 32'h0;
  assign miso2 = tgt2[31];
  always @(negedge sclk2) tgt2 = {tgt2[30:0], 1'b0};

  int          rise2 = 0;
  int          rise1 = 0;
  int          csn_rise2 = 0;
  logic [31:0] cap2 = 32'h0;
  logic [7:0]  cap1 = 8'h0;
  always @(posedge sclk2) begin rise2++; cap2 = {cap2[30:0], mosi2}; end
  always @(posedge sclk1) begin rise1++; cap1 = {cap1[6:0], mosi1}; end
  always @(posedge csn2) csn_rise2++;

  logic [7:0] got2_q[$];
  logic [7:0] got1_q[$];
  logic [7:0] exp_q[$];
  always @(posedge clk) begin
    if (bus2.rx_valid === 1'b1) got2_q.push_back(bus2.rx_data);
    if (bus1.rx_valid === 1'b1) got1_q.push_back(bus1.rx_data);
  end

  // ---------------- driver tasks ----------------
  task automatic send2(input logic [7:0] d, input logic last);
    for (int i = 0; i < 200 && bus2.tx_ready !== 1'b1; i++) @(negedge clk);
    n_chk++;
    if (bus2.tx_ready !== 1'b1) begin n_fail++; $display("FAIL send2_ready: got %b want 1", bus2.tx_ready); end
    bus2.tx_data = d; bus2.tx_last = last; bus2.tx_valid = 1'b1;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (csn2 !== 1'b1) begin n_fail++; $display("FAIL rst_csn: got %b want 1", csn2); end
    n_chk++; if (sclk2 !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk2); end
    n_chk++; if (mosi2 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi2); end
    n_chk++; if (bus2.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 0", bus2.tx_ready); end
    n_chk++; if (bus2.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", bus2.rx_valid); end
    n_chk++; if (bus2.rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", bus2.rx_data); end
    n_chk++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus2.busy); end
    n_chk++; if (irq2 !== 1'b0 || irqf2 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b%b want 00", irq2, irqf2); end
    n_chk++; if (st2 !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", st2); end
    n_chk++; if (csn1 !== 1'b1 || sclk1 !== 1'b0 || bus1.busy !== 1'b0 || st1 !== 3'd0) begin
      n_fail++; $display("FAIL rst_dut1: got csn=%b sclk=%b busy=%b st=%0d want 1 0 0 0", csn1, sclk1, bus1.busy, st1);
    end
    reset_n = 1'b1;
    #1;
    n_chk++; if (bus2.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0", bus2.tx_ready); end
    @(negedge clk);
    n_chk++; if (bus2.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_ready: got %b want 1", bus2.tx_ready); end
    n_chk++; if (bus1.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_ready1: got %b want 1", bus1.tx_ready); end
  endtask

  task automatic test_single_byte();
    int t, sc_off, rx_off, csn_off, rdy_off, base;
    sc_off = -1; rx_off = -1; csn_off = -1; rdy_off = -1;
    tgt2 = {8'h3C, 24'h0}; got2_q.delete(); base = rise2;
    for (int i = 0; i < 100 && bus2.tx_ready !== 1'b1; i++) @(negedge clk);
    bus2.tx_data = 8'hA5; bus2.tx_last = 1'b1; bus2.tx_valid = 1'b1; t = cyc;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    n_chk++; if (csn2 !== 1'b0 || mosi2 !== 1'b1) begin n_fail++; $display("FAIL single_t1: got csn=%b mosi=%b want 0 1", csn2, mosi2); end
    n_chk++; if (bus2.busy !== 1'b1 || bus2.tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_t1_busy: got busy=%b rdy=%b want 1 0", bus2.busy, bus2.tx_ready); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sclk2 === 1'b1 && sc_off < 0) sc_off = cyc - t;
      if (bus2.rx_valid === 1'b1 && rx_off < 0) rx_off = cyc - t;
      if (csn2 === 1'b1 && csn_off < 0) csn_off = cyc - t;
      if (bus2.tx_ready === 1'b1 && rdy_off < 0) rdy_off = cyc - t;
      if (cyc - t == 36) begin
        n_chk++; if (bus2.busy !== 1'b1 || st2 !== 3'd4) begin n_fail++; $display("FAIL single_gap: got busy=%b st=%0d want 1 4", bus2.busy, st2); end
      end
      if (cyc - t == 37) begin
        n_chk++; if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", bus2.busy); end
      end
    end
    n_chk++; if (sc_off != 3) begin n_fail++; $display("FAIL single_first_rise: got t+%0d want t+3", sc_off); end
    n_chk++; if (rx_off != 33) begin n_fail++; $display("FAIL single_rx_valid: got t+%0d want t+33", rx_off); end
    n_chk++; if (csn_off != 35) begin n_fail++; $display("FAIL single_csn_high: got t+%0d want t+35", csn_off); end
    n_chk++; if (rdy_off != 37) begin n_fail++; $display("FAIL single_tx_ready: got t+%0d want t+37", rdy_off); end
    n_chk++; if (rise2 - base != 8) begin n_fail++; $display("FAIL single_rises: got %0d want 8", rise2 - base); end
    n_chk++; if (cap2[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_mosi: got %h want a5", cap2[7:0]); end
    n_chk++; if (got2_q.size() != 1) begin n_fail++; $display("FAIL single_rx_count: got %0d want 1", got2_q.size()); end
    else begin
      n_chk++; if (got2_q[0] !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %h want 3c", got2_q[0]); end
    end
  endtask

  task automatic test_three_byte();
    logic [7:0] b [3];
    int base, base_csn, hold_seen, hold_bad;
    b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'h03;
    exp_q = {8'hC1, 8'h5A, 8'h7E};
    tgt2 = {8'hC1, 8'h5A, 8'h7E, 8'h00};
    got2_q.delete(); base = rise2; base_csn = csn_rise2; hold_seen = 0; hold_bad = 0;
    bus2.tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus2.tx_data = b[k]; bus2.tx_last = (k == 2);
      for (int i = 0; i < 100 && bus2.tx_ready !== 1'b1; i++) begin
        @(negedge clk);
        if (st2 === 3'd2) begin hold_seen++; if (sclk2 !== 1'b0 || csn2 !== 1'b0) hold_bad++; end
      end
      @(negedge clk);
    end
    bus2.tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    n_chk++; if (rise2 - base != 24) begin n_fail++; $display("FAIL three_rises: got %0d want 24", rise2 - base); end
    n_chk++; if (cap2[23:0] !== 24'h010203) begin n_fail++; $display("FAIL three_mosi: got %h want 010203", cap2[23:0]); end
    n_chk++; if (csn_rise2 - base_csn != 1) begin n_fail++; $display("FAIL three_csn_cont: got %0d rises want 1", csn_rise2 - base_csn); end
    n_chk++; if (hold_seen != 2 || hold_bad != 0) begin n_fail++; $display("FAIL three_hold: got seen=%0d bad=%0d want 2 0", hold_seen, hold_bad); end
    n_chk++; if (got2_q.size() != exp_q.size()) begin n_fail++; $display("FAIL three_rx_count: got %0d want %0d", got2_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        n_chk++; if (got2_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL three_rx_%0d: got %h want %h", i, got2_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_abort();
    int a, rdy_off, base;
    rdy_off = -1;
    tgt2 = {8'hFF, 24'h0}; got2_q.delete(); base = rise2;
    send2(8'h81, 1'b0);
    for (int i = 0; i < 100 && rise2 - base < 4; i++) @(negedge clk);
    n_chk++; if (sclk2 !== 1'b1 || rise2 - base != 4) begin n_fail++; $display("FAIL abort_at_rise4: got sclk=%b rises=%0d want 1 4", sclk2, rise2 - base); end
    bus2.abort = 1'b1; a = cyc;
    @(negedge clk);
    bus2.abort = 1'b0;
    n_chk++; if (csn2 !== 1'b1 || sclk2 !== 1'b0) begin n_fail++; $display("FAIL abort_pins: got csn=%b sclk=%b want 1 0", csn2, sclk2); end
    n_chk++; if (st2 !== 3'd4 || bus2.busy !== 1'b1) begin n_fail++; $display("FAIL abort_gap: got st=%0d busy=%b want 4 1", st2, bus2.busy); end
    for (int i = 0; i < 20; i++) begin
      if (bus2.tx_ready === 1'b1 && rdy_off < 0) rdy_off = cyc - a;
      @(negedge clk);
    end
    n_chk++; if (rdy_off != 3) begin n_fail++; $display("FAIL abort_ready: got a+%0d want a+3", rdy_off); end
    n_chk++; if (got2_q.size() != 0) begin n_fail++; $display("FAIL abort_no_rx: got %0d pulses want 0", got2_q.size()); end
    tgt2 = {8'h96, 24'h0}; base = rise2;
    send2(8'h3C, 1'b1);
    repeat (45) @(negedge clk);
    n_chk++; if (rise2 - base != 8 || cap2[7:0] !== 8'h3C) begin n_fail++; $display("FAIL abort_next_mosi: got rises=%0d mosi=%h want 8 3c", rise2 - base, cap2[7:0]); end
    n_chk++; if (got2_q.size() != 1 || got2_q[0] !== 8'h96) begin n_fail++; $display("FAIL abort_next_rx: got n=%0d want 1 byte 96", got2_q.size()); end
  endtask

  task automatic test_reset_mid();
    int base;
    tgt2 = {8'hAA, 24'h0}; got2_q.delete();
    send2(8'hC3, 1'b1);
    for (int i = 0; i < 50 && sclk2 !== 1'b1; i++) @(negedge clk);
    n_chk++; if (st2 !== 3'd1) begin n_fail++; $display("FAIL rmid_in_shift: got st=%0d want 1", st2); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (csn2 !== 1'b1 || sclk2 !== 1'b0 || mosi2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got csn=%b sclk=%b mosi=%b want 1 0 0", csn2, sclk2, mosi2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++; if (bus2.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_release: got %b want 0", bus2.tx_ready); end
    @(negedge clk);
    n_chk++; if (bus2.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bus2.tx_ready); end
    n_chk++; if (got2_q.size() != 0) begin n_fail++; $display("FAIL rmid_no_rx: got %0d want 0", got2_q.size()); end
    tgt2 = {8'h5A, 24'h0}; base = rise2;
    send2(8'hFF, 1'b1);
    repeat (45) @(negedge clk);
    n_chk++; if (rise2 - base != 8 || cap2[7:0] !== 8'hFF) begin n_fail++; $display("FAIL rmid_next_mosi: got rises=%0d mosi=%h want 8 ff", rise2 - base, cap2[7:0]); end
    n_chk++; if (got2_q.size() != 1 || got2_q[0] !== 8'h5A) begin n_fail++; $display("FAIL rmid_next_rx: got n=%0d want 1 byte 5a", got2_q.size()); end
  endtask

  task automatic test_clkdiv1();
    int t, base, first, last, nrise, rx_off;
    logic prev;
    first = -1; last = -1; nrise = 0; rx_off = -1;
    miso1 = 1'b1; got1_q.delete(); base = rise1;
    for (int i = 0; i < 100 && bus1.tx_ready !== 1'b1; i++) @(negedge clk);
    bus1.tx_data = 8'h00; bus1.tx_last = 1'b1; bus1.tx_valid = 1'b1; t = cyc;
    prev = sclk1;
    @(negedge clk);
    bus1.tx_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sclk1 === 1'b1 && prev === 1'b0) begin
        nrise++; if (first < 0) first = cyc - t; last = cyc - t;
      end
      if (bus1.rx_valid === 1'b1 && rx_off < 0) rx_off = cyc - t;
      prev = sclk1;
      @(negedge clk);
    end
    n_chk++; if (nrise != 8 || rise1 - base != 8) begin n_fail++; $display("FAIL div1_pulses: got %0d/%0d want 8", nrise, rise1 - base); end
    n_chk++; if (first != 2 || last - first != 14) begin n_fail++; $display("FAIL div1_period: got first=%0d span=%0d want 2 14", first, last - first); end
    n_chk++; if (rx_off != 17) begin n_fail++; $display("FAIL div1_rx_valid: got t+%0d want t+17", rx_off); end
    n_chk++; if (cap1 !== 8'h00) begin n_fail++; $display("FAIL div1_mosi: got %h want 00", cap1); end
    n_chk++; if (got1_q.size() != 1 || got1_q[0] !== 8'hFF) begin n_fail++; $display("FAIL div1_rx: got n=%0d want 1 byte ff", got1_q.size()); end
  endtask

  task automatic test_intn();
    logic exp_irq, exp_fall;
    repeat (4) @(negedge clk);
    intn = 1'b0;
    for (int off = 0; off < 7; off++) begin
      exp_irq  = INTN_EN && (off >= 2);
      exp_fall = INTN_EN && (off == 3);
      n_chk++; if (irq2 !== exp_irq || irqf2 !== exp_fall) begin
        n_fail++; $display("FAIL intn_fall_%0d: got irq=%b fall=%b want %b %b", off, irq2, irqf2, exp_irq, exp_fall);
      end
      @(negedge clk);
    end
    intn = 1'b1;
    for (int off = 0; off < 7; off++) begin
      exp_irq = INTN_EN && (off < 2);
      n_chk++; if (irq2 !== exp_irq || irqf2 !== 1'b0 || irq1 !== exp_irq || irqf1 !== 1'b0) begin
        n_fail++; $display("FAIL intn_rise_%0d: got irq=%b fall=%b want %b 0", off, irq2, irqf2, exp_irq);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset_n = 1'b0; intn = 1'b1; miso1 = 1'b0;
    bus2.tx_valid = 1'b0; bus2.tx_data = 8'h00; bus2.tx_last = 1'b0; bus2.abort = 1'b0;
    bus1.tx_valid = 1'b0; bus1.tx_data = 8'h00; bus1.tx_last = 1'b0; bus1.abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_three_byte();
    test_abort();
    test_reset_mid();
    test_clkdiv1();
    test_intn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
